// File: rtl/vga_frame_reader.sv
// vga_frame_reader: display-side reader of the dual-buffer frame store.
// Generates VGA timing from r_clk with an internal /2 pixel tick, fetches a centred
// image from buffer port B and owns the per-frame A->B copy handshake.
module vga_frame_reader #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned IMG_W    = 256,
    parameter int unsigned IMG_H    = 256,
    parameter int unsigned X_OFF    = 192,
    parameter int unsigned Y_OFF    = 112,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        r_clk,
    input  logic        rst,
    input  logic        copy_en,
    input  logic        r_done,
    input  logic [15:0] d_in,
    output logic [15:0] r_addr,
    output logic        r_rd,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [4:0]  vga_r,
    output logic [5:0]  vga_g,
    output logic [4:0]  vga_b,
    output logic        frame_start,
    output logic        copy_late
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] IX_BEG = HW'(X_OFF);
    localparam logic [HW-1:0] IX_END = HW'(X_OFF + IMG_W);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] IY_BEG = VW'(Y_OFF);
    localparam logic [VW-1:0] IY_END = VW'(Y_OFF + IMG_H);

    localparam logic [15:0] IMG_W16  = 16'(IMG_W);
    localparam logic [2:0]  REQ_LAST = 3'd7;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} copy_state_t;

    logic          pix_ce;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic          active_c, hs_on_c, vs_on_c, in_img_c, first_c;
    logic [15:0]   dx_c, dy_c, addr_c;
    logic          vblank_go_c, frame_wrap_c;

    logic          in_img1, active1, hs1, vs1, first1;

    copy_state_t   state;
    logic [2:0]    tmo;

    // Pixel tick: r_clk divided by two, first high in the second cycle after reset.
    always_ff @(posedge r_clk) begin
        if (rst) pix_ce <= 1'b0;
        else     pix_ce <= ~pix_ce;
    end

    // Raster counters, advanced once per pixel tick.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Raster position decode and image-relative read address.
    always_comb begin
        active_c     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_on_c      = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_on_c      = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        in_img_c     = (h_cnt >= IX_BEG) && (h_cnt < IX_END) &&
                       (v_cnt >= IY_BEG) && (v_cnt < IY_END);
        first_c      = (h_cnt == '0) && (v_cnt == '0);
        dx_c         = 16'(h_cnt - IX_BEG);
        dy_c         = 16'(v_cnt - IY_BEG);
        addr_c       = in_img_c ? 16'(dy_c * IMG_W16 + dx_c) : 16'h0000;
        vblank_go_c  = pix_ce && (h_cnt == '0) && (v_cnt == V_ACT) && copy_en;
        frame_wrap_c = pix_ce && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

    // Stage 1: issue the buffer read and carry the raster flags alongside it.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_addr  <= '0;
            in_img1 <= 1'b0;
            active1 <= 1'b0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            first1  <= 1'b0;
        end else if (pix_ce) begin
            r_addr  <= addr_c;
            in_img1 <= in_img_c;
            active1 <= active_c;
            hs1     <= hs_on_c;
            vs1     <= vs_on_c;
            first1  <= first_c;
        end
    end

    // Stage 2: buffer data returned, drive pixel and sync outputs together.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            de          <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_ce) begin
                de          <= active1;
                vga_r       <= in_img1 ? d_in[15:11] : 5'd0;
                vga_g       <= in_img1 ? d_in[10:5]  : 6'd0;
                vga_b       <= in_img1 ? d_in[4:0]   : 5'd0;
                hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
                vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
                frame_start <= active1 && first1;
            end
        end
    end

    // Copy handshake: one request per frame at start of vblank; r_rd never drops mid-copy.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            state     <= IDLE;
            r_rd      <= 1'b0;
            tmo       <= '0;
            copy_late <= 1'b0;
        end else begin
            if (frame_wrap_c && (state != IDLE)) copy_late <= 1'b1;
            case (state)
                IDLE: begin
                    if (vblank_go_c) begin
                        r_rd  <= 1'b1;
                        tmo   <= '0;
                        state <= r_done ? REQ : BUSY;
                    end
                end
                REQ: begin
                    if (!r_done) begin
                        state <= BUSY;
                    end else if (tmo == REQ_LAST) begin
                        r_rd  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                BUSY: begin
                    if (r_done) begin
                        r_rd  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    r_rd  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
